baud_tick_gen: RTL and testbench

- Runtime-programmable tick generator for the UPDI serial path; successor to the fixed-ratio clock divider.
- Produces a one-cycle bit_tick at each period start and a one-cycle sample_tick at a programmable phase within the period.
- Divisor and phase are reloaded through a valid/ready config port and applied glitch-free at a period boundary.
- A resync input realigns the period to an external edge, e.g. a start-bit falling edge.

---
 rtl/baud_pkg.sv | 17 +
 rtl/baud_cfg_slot.sv | 47 ++++
 rtl/baud_tick_gen.sv | 85 ++++++++
 tb/tb_baud_tick_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared types and the config validity rule for the baud tick generator.
package baud_pkg;

    localparam int unsigned BAUD_CNT_W = 16;
    localparam int unsigned MIN_DIV    = 2;

    typedef struct packed {
        logic [BAUD_CNT_W-1:0] div;
        logic [BAUD_CNT_W-1:0] phase;
    } baud_cfg_t;

    // A divisor below 2 would make wrap and period start the same cycle.
    function automatic logic baud_cfg_ok(input baud_cfg_t c);
        return (c.div >= BAUD_CNT_W'(MIN_DIV)) && (c.phase < c.div);
    endfunction

endpackage

// File: rtl/baud_cfg_slot.sv
// Single-entry pending config slot with the validity check and reject pulse.
module baud_cfg_slot
    import baud_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_cfg_valid,
    input  baud_cfg_t i_cfg,
    input  logic      i_apply,
    output logic      o_cfg_ready,
    output logic      o_cfg_err,
    output logic      o_pending_valid,
    output baud_cfg_t o_pending_cfg
);

    logic      r_pending;
    logic      r_err;
    baud_cfg_t r_cfg;
    logic      w_accept;
    logic      w_ok;

    assign w_accept = i_cfg_valid & ~r_pending;
    assign w_ok     = baud_cfg_ok(i_cfg);

    // Apply only happens while pending, and accept only while empty, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_err     <= 1'b0;
            r_cfg     <= '0;
        end else begin
            r_err <= w_accept & ~w_ok;
            if (i_apply) begin
                r_pending <= 1'b0;
            end else if (w_accept && w_ok) begin
                r_pending <= 1'b1;
                r_cfg     <= i_cfg;
            end
        end
    end

    assign o_cfg_ready     = ~r_pending;
    assign o_cfg_err       = r_err;
    assign o_pending_valid = r_pending;
    assign o_pending_cfg   = r_cfg;

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable bit/sample tick generator with boundary-aligned config reload and resync.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CNT_W         = BAUD_CNT_W,
    parameter int unsigned DEFAULT_DIV   = 5,
    parameter int unsigned DEFAULT_PHASE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             resync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic             bit_tick,
    output logic             sample_tick,
    output logic [CNT_W-1:0] cnt
);

    if (CNT_W != BAUD_CNT_W) begin : g_bad_width
        $error("baud_tick_gen: CNT_W must equal baud_pkg::BAUD_CNT_W");
    end
    if (DEFAULT_DIV < MIN_DIV) begin : g_bad_div
        $error("baud_tick_gen: DEFAULT_DIV must be at least 2");
    end
    if (DEFAULT_PHASE >= DEFAULT_DIV) begin : g_bad_phase
        $error("baud_tick_gen: DEFAULT_PHASE must be less than DEFAULT_DIV");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_phase;

    baud_cfg_t w_cfg_in;
    baud_cfg_t w_pending_cfg;
    logic      w_pending_valid;
    logic      w_wrap;
    logic      w_boundary;
    logic      w_apply;

    assign w_cfg_in = '{div: cfg_div, phase: cfg_phase};

    baud_cfg_slot u_slot (
        .clk             (clk),
        .rst             (rst),
        .i_cfg_valid     (cfg_valid),
        .i_cfg           (w_cfg_in),
        .i_apply         (w_apply),
        .o_cfg_ready     (cfg_ready),
        .o_cfg_err       (cfg_err),
        .o_pending_valid (w_pending_valid),
        .o_pending_cfg   (w_pending_cfg)
    );

    // Idle and resync cycles count as boundaries so a pending config never waits on a stalled count.
    assign w_wrap     = en & (r_cnt == (r_div - CNT_W'(1)));
    assign w_boundary = w_wrap | resync | ~en;
    assign w_apply    = w_pending_valid & w_boundary;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_div   <= CNT_W'(DEFAULT_DIV);
            r_phase <= CNT_W'(DEFAULT_PHASE);
        end else begin
            if (resync || w_apply || w_wrap) begin
                r_cnt <= '0;
            end else if (en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_apply) begin
                r_div   <= w_pending_cfg.div;
                r_phase <= w_pending_cfg.phase;
            end
        end
    end

    assign bit_tick    = en & ~rst & (r_cnt == '0);
    assign sample_tick = en & ~rst & (r_cnt == r_phase);
    assign cnt         = r_cnt;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed and randomized check of baud_tick_gen against a cycle-level reference model.
module tb_baud_tick_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        resync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_div;
    logic [15:0] cfg_phase;
    logic        cfg_err;
    logic        bit_tick;
    logic        sample_tick;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_cnt, m_div, m_phase, p_div, p_phase;
    bit m_pend, m_err;
    logic g_bit, g_samp;

    baud_tick_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .resync      (resync),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .cfg_phase   (cfg_phase),
        .cfg_err     (cfg_err),
        .bit_tick    (bit_tick),
        .sample_tick (sample_tick),
        .cnt         (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the spec: reset, else accept/reject, boundary apply, then count modulo divisor.
    task automatic model_step();
        bit acc, ok, bnd, app;
        if (rst) begin
            m_cnt = 0; m_div = 5; m_phase = 2; m_pend = 0; m_err = 0;
            return;
        end
        ok    = (int'(cfg_div) >= 2) && (int'(cfg_phase) < int'(cfg_div));
        acc   = cfg_valid && !m_pend;
        bnd   = resync || !en || (m_cnt == m_div - 1);
        app   = m_pend && bnd;
        m_err = acc && !ok;
        if (resync || app) m_cnt = 0;
        else if (en)       m_cnt = (m_cnt + 1) % m_div;
        if (app) begin
            m_div = p_div; m_phase = p_phase; m_pend = 0;
        end
        if (acc && ok) begin
            m_pend = 1; p_div = int'(cfg_div); p_phase = int'(cfg_phase);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        g_bit  = bit_tick;
        g_samp = sample_tick;
        chk("cnt",         32'(cnt),         m_cnt);
        chk("bit_tick",    32'(bit_tick),    32'(en && !rst && m_cnt == 0));
        chk("sample_tick", 32'(sample_tick), 32'(en && !rst && m_cnt == m_phase));
        chk("cfg_ready",   32'(cfg_ready),   32'(!m_pend));
        chk("cfg_err",     32'(cfg_err),     32'(m_err));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (m_cnt != v && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        assert (m_cnt == v) else begin
            errors++;
            $error("FAIL wait_cnt: observed=%0d expected=%0d", m_cnt, v);
        end
    endtask

    task automatic offer(input int d, input int p);
        cfg_valid = 1'b1;
        cfg_div   = 16'(d);
        cfg_phase = 16'(p);
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [9:0] bits_v, samp_v;
        rst = 1'b1; en = 1'b0; resync = 1'b0;
        cfg_valid = 1'b0; cfg_div = '0; cfg_phase = '0;
        p_div = 0; p_phase = 0;
        @(posedge clk);
        model_step();
        #1;
        cycle();

        // reset defaults: period 5, sample at 2
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            bits_v[9-i] = g_bit;
            samp_v[9-i] = g_samp;
        end
        chk("reset_bit_pattern",    32'(bits_v), 32'(10'b1000010000));
        chk("reset_sample_pattern", 32'(samp_v), 32'(10'b0010000100));

        // reload to div=3 phase=0 offered at cnt=1
        wait_cnt(1);
        offer(3, 0);
        chk("ready_low_after_accept", 32'(cfg_ready), 32'(0));
        repeat (12) cycle();

        // invalid configs are rejected with a single pulse
        rst = 1'b1; cycle(); rst = 1'b0;
        offer(1, 0);
        chk("err_pulse_div1", 32'(cfg_err), 32'(1));
        cycle();
        offer(5, 5);
        chk("err_pulse_phase", 32'(cfg_err), 32'(1));
        repeat (10) cycle();

        // resync at cnt=3, then held for three cycles
        wait_cnt(3);
        resync = 1'b1; cycle(); resync = 1'b0;
        chk("resync_cnt0", 32'(cnt), 32'(0));
        repeat (4) cycle();
        resync = 1'b1; repeat (3) cycle(); resync = 1'b0;
        repeat (6) cycle();

        // pending config applied on the first idle cycle
        wait_cnt(0);
        offer(4, 1);
        cycle();
        en = 1'b0; repeat (4) cycle(); en = 1'b1;
        repeat (9) cycle();

        // reset discards a pending config
        wait_cnt(1);
        offer(7, 3);
        cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rst_discard_ready", 32'(cfg_ready), 32'(1));
        repeat (12) cycle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 9) != 0);
            resync    = ($urandom_range(0, 19) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_div   = 16'($urandom_range(0, 9));
            cfg_phase = 16'($urandom_range(0, 9));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
